// File: rtl/hamming74_serial_rx.sv
// Bit-serial (7,4) Hamming receiver: frames start/7 data/stop, corrects single-bit
// errors and keeps a saturating count of corrected codewords.
module hamming74_serial_rx #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clr_count,
  output logic [3:0]       data_out,
  output logic [2:0]       syndrome_out,
  output logic             out_valid,
  output logic             corrected,
  output logic             framing_err,
  output logic [CNT_W-1:0] corr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [2:0] idx;
  logic [6:0] sr;

  logic [2:0] syn;
  logic [3:0] raw;
  logic [3:0] fix;
  logic       accept;

  // Syndrome {A,B,C} read as a bit-reversed codeword position selects the bit to flip.
  always_comb begin
    syn = {sr[0] ^ sr[2] ^ sr[4] ^ sr[6],
           sr[1] ^ sr[2] ^ sr[5] ^ sr[6],
           sr[3] ^ sr[4] ^ sr[5] ^ sr[6]};
    raw = {sr[6], sr[5], sr[4], sr[2]};
    fix = raw;
    case (syn)
      3'b110:  fix[0] = ~raw[0];
      3'b101:  fix[1] = ~raw[1];
      3'b011:  fix[2] = ~raw[2];
      3'b111:  fix[3] = ~raw[3];
      default: fix = raw;
    endcase
  end

  assign accept = (state == STOP) && sin_valid && sin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 3'd0;
      sr           <= 7'd0;
      data_out     <= 4'd0;
      syndrome_out <= 3'd0;
      out_valid    <= 1'b0;
      corrected    <= 1'b0;
      framing_err  <= 1'b0;
      corr_count   <= '0;
    end else begin
      out_valid   <= 1'b0;
      framing_err <= 1'b0;
      if (sin_valid) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state <= DATA;
              idx   <= 3'd0;
            end
          end
          DATA: begin
            sr[idx] <= sin;
            if (idx == 3'd6) state <= STOP;
            else             idx   <= idx + 3'd1;
          end
          STOP: begin
            // A bad stop bit is consumed here, never re-read as a start bit.
            state <= IDLE;
            idx   <= 3'd0;
            if (sin) begin
              data_out     <= fix;
              syndrome_out <= syn;
              corrected    <= (syn != 3'd0);
              out_valid    <= 1'b1;
            end else begin
              framing_err  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (clr_count)
        corr_count <= '0;
      else if (accept && (syn != 3'd0) && (corr_count != CNT_MAX))
        corr_count <= corr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// Directed + randomized bench for hamming74_serial_rx against a position-XOR
// Hamming reference model; counter built narrow so saturation is reachable.
module tb_hamming74_serial_rx;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, sin, sin_valid, clr_count;
  logic [3:0]       data_out;
  logic [2:0]       syndrome_out;
  logic             out_valid, corrected, framing_err;
  logic [CNT_W-1:0] corr_count;

  hamming74_serial_rx #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr_count(clr_count),
    .data_out(data_out), .syndrome_out(syndrome_out), .out_valid(out_valid),
    .corrected(corrected), .framing_err(framing_err), .corr_count(corr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic             ov;
    logic             fe;
    logic [3:0]       d;
    logic [2:0]       s;
    logic             c;
    logic [CNT_W-1:0] n;
  } ev_t;

  ev_t obs_q[$];
  int  cyc = 0;

  // Record every output pulse with the cycle it appeared in.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (out_valid || framing_err)
      obs_q.push_back('{cyc, out_valid, framing_err, data_out, syndrome_out, corrected, corr_count});
  end

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [3:0] m_data;
  int         m_cnt;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] r;
    r    = '0;
    r[2] = d[0]; r[4] = d[1]; r[5] = d[2]; r[6] = d[3];
    r[0] = d[0] ^ d[1] ^ d[3];
    r[1] = d[0] ^ d[2] ^ d[3];
    r[3] = d[1] ^ d[2] ^ d[3];
    return r;
  endfunction

  task automatic model_decode(input logic [6:0] cw, output logic [3:0] d, output logic [2:0] s);
    logic [6:0] r;
    int pos;
    r   = cw;
    pos = 0;
    for (int i = 0; i < 7; i++) if (r[i]) pos = pos ^ (i + 1);
    s = {pos[0], pos[1], pos[2]};
    if (pos != 0) r[pos-1] = ~r[pos-1];
    d = {r[6], r[5], r[4], r[2]};
  endtask

  // Stimulus
  task automatic put_bit(input logic b, input int gap);
    sin = b; sin_valid = 1'b1;
    @(negedge clk);
    repeat (gap) begin
      sin_valid = 1'b0; sin = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [6:0] cw, input logic stop, input int gap,
                            input logic clr_at_stop, output int stop_cyc);
    put_bit(1'b0, gap);
    for (int i = 0; i < 7; i++) put_bit(cw[i], gap);
    clr_count = clr_at_stop; sin = stop; sin_valid = 1'b1;
    @(negedge clk);
    stop_cyc  = cyc;
    clr_count = 1'b0; sin_valid = 1'b0; sin = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sin = 1'b1; sin_valid = 1'($urandom);
      @(negedge clk);
    end
    sin_valid = 1'b0;
  endtask

  task automatic expect_ok(input string tag, input logic [6:0] cw, input int stop_cyc, input logic clr_at_stop);
    logic [3:0] d;
    logic [2:0] s;
    ev_t e;
    model_decode(cw, d, s);
    if (clr_at_stop)                  m_cnt = 0;
    else if (s != 0 && m_cnt < CNT_MAX) m_cnt++;
    m_data = d;
    if (obs_q.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
      return;
    end
    e = obs_q.pop_front();
    chk({tag, "_ov"},   e.ov,  1);
    chk({tag, "_fe"},   e.fe,  0);
    chk({tag, "_data"}, e.d,   d);
    chk({tag, "_syn"},  e.s,   s);
    chk({tag, "_corr"}, e.c,   (s != 0));
    chk({tag, "_cnt"},  e.n,   m_cnt);
    chk({tag, "_cyc"},  e.cyc, stop_cyc);
  endtask

  task automatic expect_fe(input string tag, input int stop_cyc);
    ev_t e;
    if (obs_q.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
      return;
    end
    e = obs_q.pop_front();
    chk({tag, "_ov"},   e.ov,  0);
    chk({tag, "_fe"},   e.fe,  1);
    chk({tag, "_hold"}, e.d,   m_data);
    chk({tag, "_cnt"},  e.n,   m_cnt);
    chk({tag, "_cyc"},  e.cyc, stop_cyc);
  endtask

  task automatic expect_none(input string tag);
    chk(tag, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    int sc, sc1, sc2, k, gap;
    logic [6:0] cw;
    logic [6:0] flips[4];
    logic [2:0] syns[4];
    flips[0] = 7'h10; flips[1] = 7'h04; flips[2] = 7'h20; flips[3] = 7'h40;
    syns[0]  = 3'b101; syns[1] = 3'b110; syns[2] = 3'b011; syns[3] = 3'b111;

    rst = 1'b1; sin = 1'b1; sin_valid = 1'b0; clr_count = 1'b0;
    m_data = '0; m_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_data", data_out, 0);
    chk("rst_syn",  syndrome_out, 0);
    chk("rst_ov",   out_valid, 0);
    chk("rst_corr", corrected, 0);
    chk("rst_fe",   framing_err, 0);
    chk("rst_cnt",  corr_count, 0);
    idle(4);
    expect_none("idle_quiet");

    // Clean frame 0x55
    send_frame(7'h55, 1'b1, 0, 1'b0, sc);
    expect_ok("clean", 7'h55, sc, 1'b0);
    chk("clean_const_data", data_out, 4'b1011);
    chk("clean_const_syn",  syndrome_out, 3'b000);
    @(negedge clk);
    chk("ov_one_cycle", out_valid, 0);

    // Single data-bit errors
    for (int i = 0; i < 4; i++) begin
      send_frame(7'h55 ^ flips[i], 1'b1, 0, 1'b0, sc);
      expect_ok("data_err", 7'h55 ^ flips[i], sc, 1'b0);
      chk("data_err_const_syn",  syndrome_out, syns[i]);
      chk("data_err_const_data", data_out, 4'b1011);
      idle(1);
    end

    clr_count = 1'b1; @(negedge clk); clr_count = 1'b0; m_cnt = 0;
    chk("clr_idle", corr_count, 0);

    // Parity-bit error
    send_frame(7'h54, 1'b1, 0, 1'b0, sc);
    expect_ok("parity_err", 7'h54, sc, 1'b0);
    chk("parity_const_syn", syndrome_out, 3'b100);

    // Framing error, immediately followed by a clean frame
    send_frame(7'h55, 1'b0, 0, 1'b0, sc);
    expect_fe("framing", sc);
    cw = encode(4'($urandom));
    send_frame(cw, 1'b1, 0, 1'b0, sc);
    expect_ok("after_framing", cw, sc, 1'b0);
    idle(2);

    // Gapped strobe with sin toggling while invalid
    send_frame(7'h55, 1'b1, 3, 1'b0, sc);
    expect_ok("gapped", 7'h55, sc, 1'b0);
    chk("gapped_const_data", data_out, 4'b1011);

    // Back-to-back frames
    cw = encode(4'($urandom));
    send_frame(cw, 1'b1, 0, 1'b0, sc1);
    expect_ok("b2b_first", cw, sc1, 1'b0);
    cw = encode(4'($urandom)) ^ 7'h08;
    send_frame(cw, 1'b1, 0, 1'b0, sc2);
    expect_ok("b2b_second", cw, sc2, 1'b0);
    chk("b2b_spacing", sc2 - sc1, 9);
    idle(2);

    // Reset after r3; a valid start bit during reset must be ignored
    put_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) put_bit(7'h55 >> i, 0);
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; sin = 1'b1; sin_valid = 1'b0;
    m_data = '0; m_cnt = 0;
    idle(12);
    expect_none("midframe_reset_quiet");
    chk("midframe_reset_data", data_out, 0);
    chk("midframe_reset_cnt",  corr_count, 0);
    send_frame(7'h55, 1'b1, 0, 1'b0, sc);
    expect_ok("post_reset", 7'h55, sc, 1'b0);

    // Saturation, then clear against a simultaneous increment
    for (int i = 0; i < 4; i++) begin
      cw = encode(4'($urandom)) ^ (7'h01 << $urandom_range(0, 6));
      send_frame(cw, 1'b1, 0, 1'b0, sc);
      expect_ok("sat", cw, sc, 1'b0);
    end
    chk("sat_const", corr_count, 3);
    cw = encode(4'($urandom)) ^ 7'h40;
    send_frame(cw, 1'b1, 0, 1'b1, sc);
    expect_ok("clr_wins", cw, sc, 1'b1);
    chk("clr_wins_const", corr_count, 0);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      k   = $urandom_range(0, 9);
      gap = $urandom_range(0, 2);
      cw  = encode(4'($urandom));
      if (k >= 4 && k < 8) cw = cw ^ (7'h01 << $urandom_range(0, 6));
      if (k == 8)          cw = cw ^ 7'h03 << $urandom_range(0, 5);
      if (k == 9) begin
        send_frame(cw, 1'b0, gap, 1'b0, sc);
        expect_fe("rand_fe", sc);
      end else begin
        send_frame(cw, 1'b1, gap, 1'b0, sc);
        expect_ok("rand", cw, sc, 1'b0);
      end
      idle($urandom_range(0, 2));
    end
    idle(3);
    expect_none("final_quiet");
    chk("final_cnt", corr_count, m_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hamming74_serial_rx.md
Name: hamming74_serial_rx

Overview:
Serial front end for the (7,4) Hamming decode path. It frames a bit-serial codeword stream (start bit, 7 codeword bits, stop bit) and decodes each codeword with single-bit correction. It presents the corrected nibble and syndrome as registered outputs with a one-cycle valid strobe, and keeps a saturating count of corrected codewords. It sits directly upstream of the parallel consumer of decoded nibbles and downstream of the serial link carrying encoder output.

Parameters:
CNT_W, 8, width of the corrected-codeword counter corr_count

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
sin  input  1  serial line; idles high
sin_valid  input  1  bit strobe; sin is sampled only in cycles where sin_valid=1
clr_count  input  1  synchronous clear of corr_count
data_out  output  4  corrected information nibble {d3,d2,d1,d0}
syndrome_out  output  3  syndrome {A,B,C} of the accepted codeword
out_valid  output  1  one-cycle pulse; data_out/syndrome_out are new
corrected  output  1  with out_valid: syndrome was nonzero
framing_err  output  1  one-cycle pulse; stop bit sampled as 0
corr_count  output  CNT_W  saturating count of accepted codewords with nonzero syndrome

Behaviour:
- Reset: state IDLE, bit index 0, shift register 0. data_out, syndrome_out, out_valid, corrected, framing_err and corr_count are all 0.
- Reset mid-frame aborts the frame. No output and no counter change result from it.
- A cycle with sin_valid=0 holds all state. out_valid and framing_err still return to 0 after their pulse cycle.
- FSM:
  - IDLE: on a valid sample with sin=0, go to DATA with index 0. A valid sin=1 stays in IDLE.
  - DATA: each valid sample stores sin as r[index], LSB first (r0 first). After r6, go to STOP.
  - STOP: on a valid sample:
    - sin=1: accept the codeword and go to IDLE.
    - sin=0: pulse framing_err the next cycle, discard the codeword, go to IDLE. That 0 is not reused as a start bit.
- Code layout:
  - Data bits: d0=r2, d1=r4, d2=r5, d3=r6.
  - Parity bits: r0=d0^d1^d3, r1=d0^d2^d3, r3=d1^d2^d3.
- Syndrome:
  - A=r0^r2^r4^r6, B=r1^r2^r5^r6, C=r3^r4^r5^r6.
  - syndrome_out={A,B,C}.
- Correction:
  - 110 flips d0; 101 flips d1; 011 flips d2; 111 flips d3.
  - 000, 100, 010, 001 leave the data unchanged (no error, or a parity-bit error).
  - Double errors are not detected; the decoder miscorrects them by definition.
- Latency: on acceptance, data_out, syndrome_out and corrected update, and out_valid=1, in the cycle after the stop-bit sample. The outputs hold until the next acceptance.
- Back-to-back frames: a start bit may be sampled in the cycle immediately after the stop bit.
- corr_count:
  - Increments by 1 on each acceptance with a nonzero syndrome.
  - Saturates at 2^CNT_W-1.
  - clr_count=1 sets it to 0 next cycle; clear wins over a simultaneous increment.
  - Framing errors never change it.
- out_valid and framing_err are never asserted in the same cycle.

Test Plan:
- Clean frame: sin_valid=1 continuously, bits 0,1,0,1,0,1,0,1,1 (start, r0..r6 of 0x55, stop) -> one cycle after the stop bit: out_valid=1, data_out=4'b1011, syndrome_out=3'b000, corrected=0, corr_count=0.
- Single data error: same frame with r4 flipped (codeword 0x45) -> data_out=4'b1011, syndrome_out=3'b101, corrected=1, corr_count=1. Repeat for flips of r2, r5, r6 -> syndromes 110, 011, 111, data still 1011.
- Parity error: 0x55 with r0 flipped (0x54) -> syndrome 100, data_out=1011, corrected=1. Framing error: 0x55 frame with stop bit 0 -> framing_err pulse, no out_valid, corr_count unchanged, data_out holds its previous value.
- Gapped strobe: 0x55 frame with sin_valid low 3 cycles between every bit, and sin toggling while invalid -> identical result to the clean frame. Two frames back-to-back with no idle bit -> two out_valid pulses 9 cycles apart.
- Reset after r3 of a frame -> no out_valid; the following clean frame decodes correctly.
- Saturation with CNT_W=2: 4 corrected frames -> corr_count=3. Then clr_count asserted in the same cycle as a 5th increment -> corr_count=0.
